// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: canonical NOP, base opcodes and fetch FSM states.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            pc_src_e;
    logic [XLEN-1:0] pc_target_e;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr_d;
    logic [6:0]      opcode_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic            valid_d;

    modport master (
        input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
        output imem_addr, instr_d, opcode_d, pc_d, pc_plus4_d, valid_d
    );

    modport slave (
        output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
        input  imem_addr, instr_d, opcode_d, pc_d, pc_plus4_d, valid_d
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; flush inserts a NOP bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            valid_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, BOOT/RUN FSM and IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating fetch/flush performance counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int              CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    fetch_stage_if.master    bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_nxt_d, pc_plus4_f, target_aligned;
    logic            load_vld;

    assign pc_plus4_f     = pc_q + XLEN'(4);
    assign target_aligned = bus.pc_target_e & ~XLEN'(3);

    // In BOOT the PC holds so the word at RESET_PC is refetched once memory has settled.
    always_comb begin
        state_d  = state_q;
        pc_nxt_d = pc_plus4_f;
        load_vld = 1'b0;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else begin
            load_vld = 1'b1;
        end
        if (bus.pc_src_e) begin
            pc_nxt_d = target_aligned;
        end else if (bus.stall_f || state_q == BOOT) begin
            pc_nxt_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_nxt_d;
        end
    end

    assign bus.imem_addr = pc_q;

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.flush_d),
        .stall_i    (bus.stall_d),
        .valid_i    (load_vld),
        .instr_i    (bus.imem_rdata),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4_f),
        .instr_o    (bus.instr_d),
        .pc_o       (bus.pc_d),
        .pc_plus4_o (bus.pc_plus4_d),
        .valid_o    (bus.valid_d)
    );

    assign bus.opcode_d = bus.instr_d[6:0];

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.flush_d && !bus.stall_d && load_vld) fetch_cnt_d = sat_inc(fetch_cnt_q);
        if (bus.flush_d && bus.valid_d)               flush_cnt_d = sat_inc(flush_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; define FETCH_PERF_CNT_EN to also cover the counters.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, flush_cnt;
    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt));
`else
    fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    // Memory image: address 0 holds addi x1,x0,5; elsewhere a word derived from the address.
    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'h0050_0093 : {addr[24:0], 7'b0110011};
    endfunction

    always_comb bus.imem_rdata = imem_word(bus.imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall_f     = 1'b0;
        bus.stall_d     = 1'b0;
        bus.flush_d     = 1'b0;
        bus.pc_src_e    = 1'b0;
        bus.pc_target_e = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.instr_d !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus.instr_d, 32'h13); end
        checks++; if (bus.opcode_d !== 7'b0010011) begin errors++; $display("FAIL reset_opcode: got %b expected %b", bus.opcode_d, 7'b0010011); end
        checks++; if (bus.valid_d !== 1'b0 || bus.pc_d !== 32'h0 || bus.pc_plus4_d !== 32'h0) begin
            errors++; $display("FAIL reset_ifid: valid %b pc_d %h pc4 %h expected 0 0 0", bus.valid_d, bus.pc_d, bus.pc_plus4_d); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        do_reset();
        step();
        checks++; if (bus.valid_d !== 1'b0 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL boot_cycle: valid %b pc_f %h expected 0 0", bus.valid_d, bus.imem_addr); end
        step();
        checks++; if (bus.instr_d !== 32'h0050_0093 || bus.opcode_d !== 7'b0010011) begin
            errors++; $display("FAIL first_instr: got %h/%b expected 00500093/0010011", bus.instr_d, bus.opcode_d); end
        checks++; if (bus.pc_plus4_d !== 32'h4 || bus.pc_d !== 32'h0 || bus.valid_d !== 1'b1) begin
            errors++; $display("FAIL first_pc: pc_d %h pc4 %h valid %b expected 0 4 1", bus.pc_d, bus.pc_plus4_d, bus.valid_d); end
        for (int i = 1; i <= 3; i++) begin
            checks++; if (bus.imem_addr !== 32'(4 * i)) begin
                errors++; $display("FAIL pc_seq: got %h expected %h", bus.imem_addr, 32'(4 * i)); end
            step();
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        bus.stall_f = 1'b1;
        bus.stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.imem_addr !== 32'h8 || bus.pc_d !== 32'h4 || bus.instr_d !== imem_word(32'h4)) begin
                errors++; $display("FAIL stall_hold: pc_f %h pc_d %h instr %h expected 8 4 %h", bus.imem_addr, bus.pc_d, bus.instr_d, imem_word(32'h4)); end
        end
        idle_inputs();
        step();
        checks++; if (bus.pc_d !== 32'h8 || bus.imem_addr !== 32'hC) begin
            errors++; $display("FAIL stall_release: pc_d %h pc_f %h expected 8 c", bus.pc_d, bus.imem_addr); end
        step();
        checks++; if (bus.pc_d !== 32'hC) begin errors++; $display("FAIL stall_no_dup: pc_d %h expected c", bus.pc_d); end
    endtask

    task automatic test_redirect_flush();
        bus.pc_src_e    = 1'b1;
        bus.pc_target_e = 32'h103;
        bus.flush_d     = 1'b1;
        step();
        idle_inputs();
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redirect_align: got %h expected 100", bus.imem_addr); end
        checks++; if (bus.instr_d !== 32'h13 || bus.valid_d !== 1'b0 || bus.opcode_d !== 7'b0010011) begin
            errors++; $display("FAIL redirect_flush: instr %h valid %b expected 00000013 0", bus.instr_d, bus.valid_d); end
        step();
        checks++; if (bus.pc_d !== 32'h100 || bus.valid_d !== 1'b1 || bus.instr_d !== imem_word(32'h100)) begin
            errors++; $display("FAIL redirect_target: pc_d %h valid %b instr %h expected 100 1 %h", bus.pc_d, bus.valid_d, bus.instr_d, imem_word(32'h100)); end
    endtask

    task automatic test_redirect_stall();
        bus.pc_src_e    = 1'b1;
        bus.stall_f     = 1'b1;
        bus.pc_target_e = 32'h40;
        step();
        idle_inputs();
        checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL redirect_over_stall: got %h expected 40", bus.imem_addr); end
        step();
        bus.flush_d = 1'b1;
        bus.stall_d = 1'b1;
        step();
        idle_inputs();
        checks++; if (bus.valid_d !== 1'b0 || bus.instr_d !== 32'h13) begin
            errors++; $display("FAIL flush_over_stall: valid %b instr %h expected 0 00000013", bus.valid_d, bus.instr_d); end
    endtask

    task automatic test_wrap();
        bus.pc_src_e    = 1'b1;
        bus.pc_target_e = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h expected 0", bus.imem_addr); end
        checks++; if (bus.pc_d !== 32'hFFFF_FFFC || bus.pc_plus4_d !== 32'h0) begin
            errors++; $display("FAIL pc4_wrap: pc_d %h pc4 %h expected fffffffc 0", bus.pc_d, bus.pc_plus4_d); end
    endtask

    task automatic test_async_reset_mid_stall();
        bus.stall_f = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_addr !== 32'h0 || bus.valid_d !== 1'b0) begin
            errors++; $display("FAIL async_reset: pc_f %h valid %b expected 0 0", bus.imem_addr, bus.valid_d); end
        step();
        rst = 1'b0;
        bus.stall_f = 1'b0;
        step();
        checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL post_reset_boot: valid %b expected 0", bus.valid_d); end
        step();
        checks++; if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'h0) begin
            errors++; $display("FAIL post_reset_run: valid %b pc_d %h expected 1 0", bus.valid_d, bus.pc_d); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_counters();
        idle_inputs();
        do_reset();
        checks++; if (fetch_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
            errors++; $display("FAIL cnt_reset: fetch %0d flush %0d expected 0 0", fetch_cnt, flush_cnt); end
        step();
        repeat (9) step();
        bus.flush_d = 1'b1; step();
        bus.flush_d = 1'b0; step();
        bus.flush_d = 1'b1; step();
        bus.flush_d = 1'b0;
        checks++; if (fetch_cnt !== 32'd10) begin errors++; $display("FAIL fetch_cnt: got %0d expected 10", fetch_cnt); end
        checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL flush_cnt: got %0d expected 2", flush_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_flush();
        test_redirect_stall();
        test_wrap();
        test_async_reset_mid_stall();
`ifdef FETCH_PERF_CNT_EN
        test_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
